// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core.
//   - arbitrates IF/ID/EX/MEM stall requests into one stall vector
//   - turns exceptions into a timed flush plus a PC load
//   - turns branch redirects into a PC load, held back while the PC is stalled
//   - sticky watchdog for a PC that stays frozen too long
// Build option: define PIPE_CTRL_PERF_EN to add the stall/flush performance counters.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | pipeline advancing, no stall request seen on the last edge
// S_STALL | at least one stage held the pipeline on the last edge
// S_FLUSH | exception flush in progress, stall vector forced to zero
module pipe_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_MAX     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stallreq_if,
    input  logic              i_stallreq_id,
    input  logic              i_stallreq_ex,
    input  logic              i_stallreq_mem,
    input  logic              i_excp_req,
    input  logic [ADDR_W-1:0] i_excp_pc,
    input  logic              i_redirect_req,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [5:0]        o_stall,
    output logic              o_flush,
    output logic              o_pc_load,
    output logic [ADDR_W-1:0] o_new_pc,
    output logic              o_wdog_err,
    output logic [1:0]        o_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       o_perf_stall_cnt,
    output logic [31:0]       o_perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Flush timer is a down-counter: loaded on the exception, leaves FLUSH at zero.
    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WDOG_LIM   = 16'(WDOG_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_flush_cnt;
    logic [3:0]        w_flush_cnt_nxt;
    logic [5:0]        w_stall;
    logic              w_any_req;

    logic              r_pc_load;
    logic              w_pc_load_nxt;
    logic [ADDR_W-1:0] r_new_pc;
    logic [ADDR_W-1:0] w_new_pc_nxt;
    logic              r_pend;
    logic              w_pend_nxt;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] w_pend_pc_nxt;
    logic              w_redir_have;
    logic [ADDR_W-1:0] w_redir_tgt;

    logic [15:0]       r_wdog_cnt;
    logic [15:0]       w_wdog_cnt_nxt;
    logic              r_wdog_err;

    assign w_any_req = i_stallreq_if | i_stallreq_id | i_stallreq_ex | i_stallreq_mem;

    // Stall vector: deepest requesting stage freezes itself and everything upstream.
    always_comb begin
        w_stall = 6'b000000;
        if (r_state != S_FLUSH) begin
            if (i_stallreq_mem)     w_stall = 6'b011111;
            else if (i_stallreq_ex) w_stall = 6'b001111;
            else if (i_stallreq_id) w_stall = 6'b000111;
            else if (i_stallreq_if) w_stall = 6'b000011;
        end
    end

    // Next-state: an exception always (re)enters FLUSH and reloads the flush timer.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        if (i_excp_req) begin
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_any_req) w_state_nxt = S_STALL;
                end
                S_STALL: begin
                    if (!w_any_req) w_state_nxt = S_RUN;
                end
                S_FLUSH: begin
                    if (r_flush_cnt == 4'd0) w_state_nxt = S_RUN;
                    else                     w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    // State register and flush timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // PC-load arbitration: exception beats redirect; a redirect waits while the PC is
    // stalled, and also for one cycle after a load so pc_load never pulses back to back.
    always_comb begin
        w_redir_have  = i_redirect_req | r_pend;
        w_redir_tgt   = i_redirect_req ? i_redirect_pc : r_pend_pc;
        w_pc_load_nxt = 1'b0;
        w_new_pc_nxt  = r_new_pc;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
        if (i_excp_req) begin
            w_pc_load_nxt = 1'b1;
            w_new_pc_nxt  = i_excp_pc;
            w_pend_nxt    = 1'b0;
        end else if (r_state == S_FLUSH) begin
            w_pend_nxt    = 1'b0;
        end else if (w_redir_have && !w_stall[0] && !r_pc_load) begin
            w_pc_load_nxt = 1'b1;
            w_new_pc_nxt  = w_redir_tgt;
            w_pend_nxt    = 1'b0;
        end else if (i_redirect_req) begin
            w_pend_nxt    = 1'b1;
            w_pend_pc_nxt = i_redirect_pc;
        end
    end

    // PC-load command and pending redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_load <= 1'b0;
            r_new_pc  <= '0;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_pc_load <= w_pc_load_nxt;
            r_new_pc  <= w_new_pc_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end

    // Watchdog: run length of consecutive PC stalls, saturating at the limit.
    always_comb begin
        w_wdog_cnt_nxt = 16'd0;
        if (w_stall[0]) begin
            w_wdog_cnt_nxt = (r_wdog_cnt == WDOG_LIM) ? r_wdog_cnt : r_wdog_cnt + 16'd1;
        end
    end

    // Watchdog counter and its sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt <= 16'd0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_nxt;
            r_wdog_err <= r_wdog_err | (w_wdog_cnt_nxt == WDOG_LIM);
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Free-running performance counters; every exception edge is a FLUSH entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cnt <= 32'd0;
            r_perf_flush_cnt <= 32'd0;
        end else begin
            if (w_stall[0]) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            if (i_excp_req) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
        end
    end

    assign o_perf_stall_cnt = r_perf_stall_cnt;
    assign o_perf_flush_cnt = r_perf_flush_cnt;
`else
    // Performance counters not built.
`endif

    assign o_stall    = w_stall;
    assign o_flush    = (r_state == S_FLUSH);
    assign o_pc_load  = r_pc_load;
    assign o_new_pc   = r_new_pc;
    assign o_wdog_err = r_wdog_err;
    assign o_state    = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: stall-vector table, hand-written sequences for the multi-cycle
// cases, then randomized traffic against a cycle-level reference model.
module tb_pipe_ctrl;
    localparam int AW = 32;
    localparam int FC = 2;
    localparam int WM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;       // [0]=if [1]=id [2]=ex [3]=mem
    logic          excp;
    logic [AW-1:0] epc;
    logic          redir;
    logic [AW-1:0] rpc;

    logic [5:0]    o_stall;
    logic          o_flush;
    logic          o_pc_load;
    logic [AW-1:0] o_new_pc;
    logic          o_wdog_err;
    logic [1:0]    o_state;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .WDOG_MAX(WM)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_stallreq_if  (req[0]),
        .i_stallreq_id  (req[1]),
        .i_stallreq_ex  (req[2]),
        .i_stallreq_mem (req[3]),
        .i_excp_req     (excp),
        .i_excp_pc      (epc),
        .i_redirect_req (redir),
        .i_redirect_pc  (rpc),
        .o_stall        (o_stall),
        .o_flush        (o_flush),
        .o_pc_load      (o_pc_load),
        .o_new_pc       (o_new_pc),
        .o_wdog_err     (o_wdog_err),
        .o_state        (o_state)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks cycles since the last exception edge, the length of
    // the current PC-stall run, a one-deep pending redirect and the last PC load.
    int            m_since;
    int            m_run;
    bit            m_err;
    bit            m_pcload;
    logic [AW-1:0] m_newpc;
    bit            m_pend;
    logic [AW-1:0] m_pend_pc;
    int            m_state;

    function automatic bit m_flush_now();
        return (m_since >= 1) && (m_since <= FC);
    endfunction

    function automatic logic [5:0] exp_stall(input logic [3:0] r, input bit fl);
        int k;
        k = -1;
        if (fl) return 6'd0;
        for (int i = 0; i < 4; i++) if (r[i]) k = i;
        if (k < 0) return 6'd0;
        return 6'((1 << (k + 2)) - 1);
    endfunction

    task automatic model_reset();
        m_since   = 1000;
        m_run     = 0;
        m_err     = 0;
        m_pcload  = 0;
        m_newpc   = '0;
        m_pend    = 0;
        m_pend_pc = '0;
        m_state   = 0;
    endtask

    task automatic model_edge();
        bit            fl;
        bit            s0;
        bit            have;
        logic [AW-1:0] tgt;
        fl = m_flush_now();
        s0 = !fl && (req != 4'd0);
        if (rst) begin
            model_reset();
            return;
        end
        if (excp) begin
            m_pcload = 1; m_newpc = epc; m_pend = 0;
        end else if (fl) begin
            m_pcload = 0;
        end else begin
            have = redir || m_pend;
            tgt  = redir ? rpc : m_pend_pc;
            if (have && !s0 && !m_pcload) begin
                m_pcload = 1; m_newpc = tgt; m_pend = 0;
            end else begin
                m_pcload = 0;
                if (redir) begin m_pend = 1; m_pend_pc = rpc; end
            end
        end
        if (excp) m_since = 1;
        else if (m_since < 1000) m_since++;
        m_state = m_flush_now() ? 2 : ((req != 4'd0 && !fl) ? 1 : 0);
        m_run = s0 ? m_run + 1 : 0;
        if (m_run >= WM) m_err = 1;
    endtask

    // One clock: check the combinational stall, advance the model, check registers.
    task automatic tick();
        #1;
        chk("stall", o_stall, exp_stall(req, m_flush_now()));
        model_edge();
        @(posedge clk);
        #1;
        chk("flush", o_flush, m_flush_now());
        chk("pc_load", o_pc_load, m_pcload);
        chk("new_pc", o_new_pc, m_newpc);
        chk("wdog_err", o_wdog_err, m_err);
        chk("state", o_state, m_state);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'b0001, 6'b000011};
        vecs[1] = '{4'b0010, 6'b000111};
        vecs[2] = '{4'b0100, 6'b001111};
        vecs[3] = '{4'b1000, 6'b011111};
        vecs[4] = '{4'b0011, 6'b000111};
        vecs[5] = '{4'b0101, 6'b001111};
        vecs[6] = '{4'b1111, 6'b011111};
        vecs[7] = '{4'b0000, 6'b000000};
        vecs[8] = '{4'b1010, 6'b011111};

        rst = 1'b1; req = 4'd0; excp = 1'b0; epc = '0; redir = 1'b0; rpc = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_flush", o_flush, 0);
        chk("rst_pc_load", o_pc_load, 0);
        chk("rst_new_pc", o_new_pc, 0);
        chk("rst_wdog", o_wdog_err, 0);
        chk("rst_state", o_state, 0);
        chk("rst_stall", o_stall, 0);
        rst = 1'b0;
        tick();

        // Stall priority table.
        for (int i = 0; i < 9; i++) begin
            req = vecs[i].req;
            #1;
            chk("tbl_stall", o_stall, vecs[i].exp);
            tick();
        end
        req = 4'd0;
        tick();
        tick();

        // ID hazard for three cycles.
        for (int i = 0; i < 3; i++) begin
            req = 4'b0010;
            #1;
            chk("id_stall", o_stall, 6'b000111);
            if (i > 0) chk("id_state", o_state, 1);
            tick();
        end
        req = 4'd0;
        #1;
        chk("id_release_stall", o_stall, 6'b000000);
        tick();
        chk("id_release_state", o_state, 0);

        // IF+EX then IF alone.
        req = 4'b0101;
        #1;
        chk("ifex_stall", o_stall, 6'b001111);
        tick();
        req = 4'b0001;
        #1;
        chk("if_stall", o_stall, 6'b000011);
        tick();
        req = 4'd0;
        tick();
        tick();

        // Exception, two-cycle flush; a MEM request during flush must not stall.
        excp = 1'b1; epc = 32'h0000_0020;
        tick();
        excp = 1'b0; req = 4'b1000;
        #1;
        chk("exc_flush1", o_flush, 1);
        chk("exc_pc_load1", o_pc_load, 1);
        chk("exc_new_pc", o_new_pc, 32'h20);
        chk("exc_stall1", o_stall, 0);
        chk("exc_state", o_state, 2);
        tick();
        chk("exc_flush2", o_flush, 1);
        chk("exc_pc_load2", o_pc_load, 0);
        chk("exc_stall2", o_stall, 0);
        tick();
        chk("exc_done_state", o_state, 0);
        chk("exc_done_flush", o_flush, 0);
        req = 4'd0;
        tick();
        tick();

        // Redirect held pending across a four-cycle MEM stall.
        for (int i = 0; i < 4; i++) begin
            req = 4'b1000; redir = (i == 0); rpc = 32'h0000_1000;
            tick();
            redir = 1'b0;
            chk("redir_hold", o_pc_load, 0);
        end
        req = 4'd0;
        tick();
        chk("redir_issue", o_pc_load, 1);
        chk("redir_pc", o_new_pc, 32'h1000);
        tick();
        chk("redir_once", o_pc_load, 0);

        // Exception and redirect on the same edge: exception only.
        excp = 1'b1; epc = 32'h40; redir = 1'b1; rpc = 32'h80;
        tick();
        excp = 1'b0; redir = 1'b0;
        chk("both_pc_load", o_pc_load, 1);
        chk("both_new_pc", o_new_pc, 32'h40);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("both_no_redir", o_pc_load, 0);
            chk("both_pc_kept", o_new_pc, 32'h40);
        end

        // Unstalled redirect goes out on the next cycle.
        redir = 1'b1; rpc = 32'h300;
        tick();
        redir = 1'b0;
        chk("redir_fast", o_pc_load, 1);
        chk("redir_fast_pc", o_new_pc, 32'h300);
        tick();

        // Reset in the middle of a flush.
        excp = 1'b1; epc = 32'h500;
        tick();
        excp = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstflush_pc_load", o_pc_load, 0);
        chk("rstflush_flush", o_flush, 0);
        chk("rstflush_state", o_state, 0);
        chk("rstflush_new_pc", o_new_pc, 0);

        // Watchdog: EX held ten cycles.
        req = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("wdog_ramp", o_wdog_err, (i >= WM) ? 1 : 0);
        end
        req = 4'd0;
        tick();
        tick();
        chk("wdog_sticky", o_wdog_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wdog_rst", o_wdog_err, 0);

        // Randomized traffic; odd segments are stall-heavy to reach the watchdog.
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 80; c++) begin
                rst = ($urandom_range(63) == 0);
                if (seg % 2 == 1)
                    req = ($urandom_range(9) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
                else
                    req = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'd0;
                excp  = ($urandom_range(15) == 0);
                epc   = $urandom & ~32'h3;
                redir = ($urandom_range(4) == 0);
                rpc   = $urandom & ~32'h3;
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage integer core. It arbitrates stall requests from the IF, ID, EX and MEM stages and produces one stall vector that drives pc_reg, if_id, id_ex, ex_mem and mem_wb. It also sequences exception flushes and branch redirects into a PC-load command. A stall watchdog flags a pipeline that stays frozen too long.

Parameters:
ADDR_W, 32, width of instruction addresses (new_pc, excp_pc, redirect_pc)
FLUSH_CYCLES, 1, number of cycles flush stays asserted per exception (1..15)
WDOG_MAX, 255, consecutive stall[0] cycles before wdog_err sets (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset
stallreq_if  in  1  fetch stage waiting on instruction memory
stallreq_id  in  1  decode load-use hazard
stallreq_ex  in  1  multi-cycle EX operation busy
stallreq_mem  in  1  data memory not ready
excp_req  in  1  exception taken, one-cycle or level
excp_pc  in  ADDR_W  exception handler address, valid with excp_req
redirect_req  in  1  branch/jump redirect request
redirect_pc  in  ADDR_W  redirect target, valid with redirect_req
stall  out  6  [0]=pc, [1]=if_id, [2]=id_ex, [3]=ex_mem, [4]=mem_wb, [5]=wb
flush  out  1  clear all pipeline registers to ZeroWord
pc_load  out  1  one-cycle command: pc_reg loads new_pc
new_pc  out  ADDR_W  target for pc_load
wdog_err  out  1  sticky stall-timeout flag
state  out  2  0=RUN, 1=STALL, 2=FLUSH

Behaviour:
- Reset: synchronous, active-high rst. All registered outputs go to 0: flush=0, pc_load=0, new_pc=0, wdog_err=0, state=RUN. The pending redirect, the flush counter and the watchdog counter clear.
- Stall vector: combinational from the requests and state, highest stage wins.
  - mem -> 011111
  - else ex -> 001111
  - else id -> 000111
  - else if -> 000011
  - else 000000
  - In FLUSH, stall=000000 regardless of requests.
- States:
  - RUN -> STALL when any stallreq is high and excp_req is low.
  - STALL -> RUN when all stallreq are low.
  - RUN/STALL -> FLUSH on excp_req (priority over everything).
  - FLUSH -> RUN after FLUSH_CYCLES cycles.
- Exception: excp_req sampled at clk edge N. From cycle N+1:
  - flush=1 for exactly FLUSH_CYCLES cycles.
  - pc_load=1 in the first of those cycles only.
  - new_pc = excp_pc captured at edge N.
  - Any pending redirect is discarded.
  - excp_req during FLUSH re-captures excp_pc, restarts the FLUSH counter and reissues pc_load.
- Redirect: redirect_req at edge N, with no exception and stall[0]=0 -> pc_load=1 and new_pc=redirect_pc in cycle N+1, flush stays 0.
  - If stall[0]=1, the target is held pending and issued in the cycle after stall[0] first reads 0.
  - A new redirect_req while one is pending overwrites the target.
  - redirect_req in FLUSH is ignored.
- Simultaneous excp_req and redirect_req: the exception wins and the redirect is dropped.
- pc_load is never high for two consecutive cycles unless excp_req restarts FLUSH.
- Watchdog: a 16-bit counter increments each cycle stall[0]=1 and clears when stall[0]=0. It saturates at WDOG_MAX. When it reaches WDOG_MAX, wdog_err sets and stays set until rst.
- Reset mid-FLUSH or mid-stall: everything returns to reset values on the next edge with no pc_load.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0]. Both reset to 0 and wrap at 2^32.
  - perf_stall_cnt counts cycles with stall[0]=1.
  - perf_flush_cnt counts FLUSH entries, including restarts.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

Test Plan:
- stallreq_id=1 for 3 cycles, others 0 -> stall=000111 for those 3 cycles, state=STALL, then stall=000000 and state=RUN.
- stallreq_if=1 and stallreq_ex=1 together -> stall=001111; drop stallreq_ex -> stall=000011.
- excp_req=1 for 1 cycle with excp_pc=0x0000_0020 and FLUSH_CYCLES=2 -> next cycle flush=1, pc_load=1, new_pc=0x20, stall=0; following cycle flush=1, pc_load=0; then state=RUN.
- redirect_req with redirect_pc=0x0000_1000 while stallreq_mem=1 for 4 cycles -> no pc_load during the stall; pc_load=1 and new_pc=0x1000 in the cycle after stall[0]=0.
- Same-cycle excp_req (excp_pc=0x40) and redirect_req (0x80) -> a single pc_load with new_pc=0x40; 0x80 is never issued.
- WDOG_MAX=8 and stallreq_ex held 10 cycles -> wdog_err=1 from the cycle after the 8th stalled cycle and stays 1 after the stall ends; rst clears it.
